// File: rtl/ball_motion_ctrl_pkg.sv
// Shared definitions for the bouncing-ball datapath: FSM encodings and screen geometry.
// The timing generator and the renderer also use these.
package ball_motion_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_e;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int BALL_SIZE = 10;

    localparam int POS_X_W = 10;
    localparam int POS_Y_W = 9;

    // Counter width for a modulo-n counter; a modulo-1 counter still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ball_motion_ctrl_frame_divider.sv
// Modulo-P_MOD counter advanced by frame pulses.
// o_Wrap is a combinational strobe that is high on the enabled pulse that returns the count to zero.
module ball_motion_ctrl_frame_divider
    import ball_motion_ctrl_pkg::*;
#(
    parameter int P_MOD = 2
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Clr,
    input  logic i_En,
    output logic o_Wrap
);

    localparam int              C_W    = cnt_w(P_MOD);
    localparam logic [C_W-1:0]  C_LAST = C_W'(P_MOD - 1);

    logic [C_W-1:0] r_count;

    assign o_Wrap = i_En && (r_count == C_LAST);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_count <= '0;
        end else if (i_Clr) begin
            r_count <= '0;
        end else if (i_En) begin
            r_count <= o_Wrap ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball sequencer: serve/run/pause FSM, ball position and direction,
// step enable for the pixel generator, and a wall-contact strobe.
module ball_motion_ctrl
    import ball_motion_ctrl_pkg::*;
#(
    parameter int P_H_VISIBLE    = H_VISIBLE,
    parameter int P_V_VISIBLE    = V_VISIBLE,
    parameter int P_BALL_SIZE    = BALL_SIZE,
    parameter int P_START_X      = 316,
    parameter int P_START_Y      = 100,
    parameter int P_SERVE_FRAMES = 60,
    parameter int P_STEP_DIV     = 1
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_VReset,
    input  logic               i_Start,
    input  logic               i_Pause,
    output logic               o_XDir,
    output logic               o_YDir,
    output logic               o_Move,
    output logic [POS_X_W-1:0] o_PosX,
    output logic [POS_Y_W-1:0] o_PosY,
    output logic               o_Bounce,
    output logic [1:0]         o_State
);

    localparam logic [POS_X_W-1:0] C_X_MIN   = POS_X_W'(1);
    localparam logic [POS_Y_W-1:0] C_Y_MIN   = POS_Y_W'(1);
    localparam logic [POS_X_W-1:0] C_X_MAX   = POS_X_W'(P_H_VISIBLE - P_BALL_SIZE + 1);
    localparam logic [POS_Y_W-1:0] C_Y_MAX   = POS_Y_W'(P_V_VISIBLE - P_BALL_SIZE + 1);
    localparam logic [POS_X_W-1:0] C_START_X = POS_X_W'(P_START_X);
    localparam logic [POS_Y_W-1:0] C_START_Y = POS_Y_W'(P_START_Y);

    localparam bit C_START_OK =
        (P_START_X > 1) && (P_START_X < P_H_VISIBLE - P_BALL_SIZE + 1) &&
        (P_START_Y > 1) && (P_START_Y < P_V_VISIBLE - P_BALL_SIZE + 1);

    state_e               r_state;
    state_e               w_state_nxt;
    logic                 r_pending;
    logic                 r_XDir;
    logic                 r_YDir;
    logic                 r_Move;
    logic                 r_Bounce;
    logic [POS_X_W-1:0]   r_PosX;
    logic [POS_Y_W-1:0]   r_PosY;

    logic                 w_serve_en;
    logic                 w_serve_clr;
    logic                 w_serve_wrap;
    logic                 w_step_en;
    logic                 w_step;
    logic [POS_X_W-1:0]   w_x_next;
    logic [POS_Y_W-1:0]   w_y_next;
    logic                 w_x_lo;
    logic                 w_x_hi;
    logic                 w_y_lo;
    logic                 w_y_hi;

    assign w_serve_en  = (r_state == ST_SERVE) && i_VReset;
    assign w_serve_clr = (r_state == ST_IDLE) && i_VReset;
    assign w_step_en   = (r_state == ST_RUN) && i_VReset && !i_Pause;

    ball_motion_ctrl_frame_divider #(.P_MOD(P_SERVE_FRAMES)) u_serve_div (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Clr   (w_serve_clr),
        .i_En    (w_serve_en),
        .o_Wrap  (w_serve_wrap)
    );

    ball_motion_ctrl_frame_divider #(.P_MOD(P_STEP_DIV)) u_step_div (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Clr   (1'b0),
        .i_En    (w_step_en),
        .o_Wrap  (w_step)
    );

    // Edge tests look at the post-step position so the flip lands with the step itself.
    assign w_x_next = r_XDir ? r_PosX + 1'b1 : r_PosX - 1'b1;
    assign w_y_next = r_YDir ? r_PosY + 1'b1 : r_PosY - 1'b1;
    assign w_x_lo   = (w_x_next == C_X_MIN);
    assign w_x_hi   = (w_x_next == C_X_MAX);
    assign w_y_lo   = (w_y_next == C_Y_MIN);
    assign w_y_hi   = (w_y_next == C_Y_MAX);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_VReset && (r_pending || i_Start)) w_state_nxt = ST_SERVE;
            ST_SERVE: if (w_serve_wrap) w_state_nxt = ST_RUN;
            ST_RUN:   if (i_VReset && i_Pause) w_state_nxt = ST_PAUSE;
            ST_PAUSE: if (i_VReset && !i_Pause) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_pending <= 1'b0;
            r_Move    <= 1'b0;
            r_Bounce  <= 1'b0;
            r_XDir    <= 1'b1;
            r_YDir    <= 1'b1;
            r_PosX    <= C_START_X;
            r_PosY    <= C_START_Y;
        end else begin
            // A start request only survives while IDLE waits for the next frame.
            r_pending <= (r_state == ST_IDLE) && !i_VReset && (r_pending || i_Start);
            r_Bounce  <= w_step && (w_x_lo || w_x_hi || w_y_lo || w_y_hi);
            if (i_VReset) begin
                r_Move <= w_step;
            end
            if (w_step) begin
                r_PosX <= w_x_next;
                r_PosY <= w_y_next;
                if (w_x_lo) r_XDir <= 1'b1;
                if (w_x_hi) r_XDir <= 1'b0;
                if (w_y_lo) r_YDir <= 1'b1;
                if (w_y_hi) r_YDir <= 1'b0;
            end
        end
    end

    assign o_XDir   = r_XDir;
    assign o_YDir   = r_YDir;
    assign o_Move   = r_Move;
    assign o_PosX   = r_PosX;
    assign o_PosY   = r_PosY;
    assign o_Bounce = r_Bounce;
    assign o_State  = r_state;

    a_start_inside: assert property (@(posedge i_Clk) C_START_OK);

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Randomised frame-level bench for ball_motion_ctrl: two instances (default and a
// divide-by-3 variant aimed at a corner) against a frame-rule reference model.
module tb_ball_motion_ctrl;

  localparam int X_MAX = 640 - 10 + 1;
  localparam int Y_MAX = 480 - 10 + 1;

  typedef struct {
    int sx;
    int sy;
    int serve_n;
    int div_n;
  } cfg_t;

  typedef struct {
    int mode;
    int serve;
    int div;
    int x;
    int y;
    int xd;
    int yd;
    int move;
    int bounce;
    int pend;
  } model_t;

  typedef struct packed {
    logic [1:0] st;
    logic [9:0] x;
    logic [8:0] y;
    logic       xd;
    logic       yd;
    logic       mv;
    logic       bn;
  } snap_t;

  localparam int SW = $bits(snap_t);
  localparam cfg_t CFG_A = '{sx: 316, sy: 100, serve_n: 60, div_n: 1};
  localparam cfg_t CFG_B = '{sx: 260, sy: 100, serve_n: 4,  div_n: 3};

  logic clk = 1'b0;
  logic rst_n, vreset, start, pause;
  logic a_xd, a_yd, a_mv, a_bn, b_xd, b_yd, b_mv, b_bn;
  logic [9:0] a_x, b_x;
  logic [8:0] a_y, b_y;
  logic [1:0] a_st, b_st;

  logic [SW-1:0] exp_a_q[$];
  logic [SW-1:0] exp_b_q[$];
  model_t ma, mb;
  snap_t  cur_a, cur_b;
  logic   vr_seen = 1'b0;
  int     total = 0;
  int     bad = 0;

  // ---------------- clock / reset / DUTs ----------------
  always #5 clk = ~clk;

  ball_motion_ctrl dut_a (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_VReset(vreset), .i_Start(start), .i_Pause(pause),
    .o_XDir(a_xd), .o_YDir(a_yd), .o_Move(a_mv), .o_PosX(a_x), .o_PosY(a_y),
    .o_Bounce(a_bn), .o_State(a_st)
  );

  ball_motion_ctrl #(.P_START_X(260), .P_START_Y(100), .P_SERVE_FRAMES(4), .P_STEP_DIV(3)) dut_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_VReset(vreset), .i_Start(start), .i_Pause(pause),
    .o_XDir(b_xd), .o_YDir(b_yd), .o_Move(b_mv), .o_PosX(b_x), .o_PosY(b_y),
    .o_Bounce(b_bn), .o_State(b_st)
  );

  // ---------------- reference model ----------------
  function automatic model_t model_reset(input cfg_t c);
    model_t m;
    m = '{mode: 0, serve: 0, div: 0, x: c.sx, y: c.sy, xd: 1, yd: 1, move: 0, bounce: 0, pend: 0};
    return m;
  endfunction

  // Effect of one frame-start pulse, with the pause level seen on that pulse.
  function automatic model_t model_frame(input model_t m_in, input cfg_t c, input bit pz);
    model_t m;
    m = m_in;
    m.bounce = 0;
    m.move = 0;
    case (m.mode)
      0: if (m.pend != 0) begin
        m.mode = 1;
        m.serve = 0;
        m.pend = 0;
      end
      1: if (m.serve == c.serve_n - 1) m.mode = 2;
         else m.serve = m.serve + 1;
      2: if (pz) m.mode = 3;
         else begin
           m.div = m.div + 1;
           if (m.div == c.div_n) begin
             m.div = 0;
             m.move = 1;
             m.x = m.x + ((m.xd != 0) ? 1 : -1);
             m.y = m.y + ((m.yd != 0) ? 1 : -1);
             if (m.x == 1)     begin m.xd = 1; m.bounce = 1; end
             if (m.x == X_MAX) begin m.xd = 0; m.bounce = 1; end
             if (m.y == 1)     begin m.yd = 1; m.bounce = 1; end
             if (m.y == Y_MAX) begin m.yd = 0; m.bounce = 1; end
           end
         end
      default: if (!pz) m.mode = 2;
    endcase
    return m;
  endfunction

  function automatic snap_t to_snap(input model_t m);
    snap_t s;
    s.st = 2'(m.mode);
    s.x  = 10'(m.x);
    s.y  = 9'(m.y);
    s.xd = (m.xd != 0);
    s.yd = (m.yd != 0);
    s.mv = (m.move != 0);
    s.bn = (m.bounce != 0);
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("st=%0d pos=(%0d,%0d) dir=%0d/%0d move=%0d bounce=%0d",
                     s.st, s.x, s.y, s.xd, s.yd, s.mv, s.bn);
  endfunction

  task automatic check(input string nm, input snap_t act, input snap_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %s, expected %s", nm, $time, fmt(act), fmt(exp));
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) vr_seen <= vreset && rst_n;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_a = to_snap(model_reset(CFG_A));
      cur_b = to_snap(model_reset(CFG_B));
    end else if (vr_seen) begin
      if (exp_a_q.size() == 0 || exp_b_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL queue_underflow @%0t: got empty queue, expected a pending frame", $time);
      end else begin
        cur_a = snap_t'(exp_a_q.pop_front());
        cur_b = snap_t'(exp_b_q.pop_front());
      end
    end
    check("dut_a", {a_st, a_x, a_y, a_xd, a_yd, a_mv, a_bn}, cur_a);
    check("dut_b", {b_st, b_x, b_y, b_xd, b_yd, b_mv, b_bn}, cur_b);
    cur_a.bn = 1'b0;
    cur_b.bn = 1'b0;
  end

  // ---------------- driver tasks ----------------
  task automatic frame(input bit pz, input bit st, input int gap);
    @(negedge clk);
    vreset = 1'b1;
    start = 1'b0;
    pause = pz;
    ma = model_frame(ma, CFG_A, pz);
    mb = model_frame(mb, CFG_B, pz);
    exp_a_q.push_back(to_snap(ma));
    exp_b_q.push_back(to_snap(mb));
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      vreset = 1'b0;
      start = st && (i == 0);
      if (start) begin
        if (ma.mode == 0) ma.pend = 1;
        if (mb.mode == 0) mb.pend = 1;
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Asserts reset between clock edges and checks outputs before any edge arrives.
  task automatic async_reset(input string nm);
    #2;
    rst_n = 1'b0;
    #1;
    ma = model_reset(CFG_A);
    mb = model_reset(CFG_B);
    check({nm, "_a"}, {a_st, a_x, a_y, a_xd, a_yd, a_mv, a_bn}, to_snap(ma));
    check({nm, "_b"}, {b_st, b_x, b_y, b_xd, b_yd, b_mv, b_bn}, to_snap(mb));
    exp_a_q.delete();
    exp_b_q.delete();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    vreset = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    ma = model_reset(CFG_A);
    mb = model_reset(CFG_B);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;

    repeat (3) frame(1'b0, 1'b0, $urandom_range(1, 3));
    frame(1'b0, 1'b1, 2);
    repeat (60) frame(1'(($urandom_range(0, 3) == 0)), 1'(($urandom_range(0, 5) == 0)),
                      $urandom_range(1, 3));
    repeat (4) frame(1'b0, 1'b0, 1);
    repeat (5) frame(1'b1, 1'b0, 1);
    repeat (4) frame(1'b0, 1'b0, 1);

    for (int f = 0; f < 1500; f++) begin
      frame(1'(($urandom_range(0, 15) == 0)), 1'(($urandom_range(0, 7) == 0)),
            $urandom_range(1, 3));
    end

    repeat (3) frame(1'b1, 1'b0, 2);
    async_reset("rst_mid_pause");

    frame(1'b0, 1'b1, 2);
    repeat (10) frame(1'b0, 1'b0, 2);
    async_reset("rst_mid_serve");
    repeat (3) frame(1'b0, 1'b0, 2);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion by %0t, expected run to finish", $time);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
